// File: rtl/img_stream_engine.sv
// ============================================================================
// Module  : img_stream_engine
// Brief   : Raster pixel engine (pass/brighten/darken/invert/threshold/shrink)
//           reading a sync-read pixel memory and emitting a valid/ready stream.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module img_stream_engine #(
  parameter int WIDTH  = 30,
  parameter int HEIGHT = 30,
  parameter int CH     = 3,
  parameter int CW     = 8,
  parameter int FACTOR = 2,
  parameter int AW     = $clog2(WIDTH*HEIGHT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CW-1:0]    level,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr,
  input  logic [CH*CW-1:0] rd_data,
  output logic [CH*CW-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_sof,
  output logic             m_eol,
  output logic             m_eof,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);

  localparam logic [XW-1:0] c_ow_full_m1 = XW'(WIDTH - 1);
  localparam logic [XW-1:0] c_ow_shr_m1  = XW'(WIDTH / FACTOR - 1);
  localparam logic [YW-1:0] c_oh_full_m1 = YW'(HEIGHT - 1);
  localparam logic [YW-1:0] c_oh_shr_m1  = YW'(HEIGHT / FACTOR - 1);
  localparam logic [AW-1:0] c_col_shr    = AW'(FACTOR);
  localparam logic [AW-1:0] c_row_full   = AW'(WIDTH);
  localparam logic [AW-1:0] c_row_shr    = AW'(FACTOR * WIDTH);

  localparam logic [2:0] c_mode_bright = 3'd1;
  localparam logic [2:0] c_mode_dark   = 3'd2;
  localparam logic [2:0] c_mode_inv    = 3'd3;
  localparam logic [2:0] c_mode_thr    = 3'd4;
  localparam logic [2:0] c_mode_shrink = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_LAT  = 3'd2,
    S_OUT  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_mode;
  logic [CW-1:0]     r_level;
  logic [XW-1:0]     r_ox;
  logic [YW-1:0]     r_oy;
  logic [AW-1:0]     r_row_base;
  logic [AW-1:0]     r_col_off;
  logic [CH*CW-1:0]  r_m_data;
  logic              r_sof;
  logic              r_eol;
  logic              r_eof;
  logic              r_err;

  logic              w_mode_ok;
  logic              w_shrink;
  logic [XW-1:0]     w_ow_m1;
  logic [YW-1:0]     w_oh_m1;
  logic [AW-1:0]     w_col_step;
  logic [AW-1:0]     w_row_step;
  logic [CH*CW-1:0]  w_result;

  assign w_mode_ok  = (mode <= c_mode_shrink);
  assign w_shrink   = (r_mode == c_mode_shrink);
  assign w_ow_m1    = w_shrink ? c_ow_shr_m1 : c_ow_full_m1;
  assign w_oh_m1    = w_shrink ? c_oh_shr_m1 : c_oh_full_m1;
  assign w_col_step = w_shrink ? c_col_shr   : AW'(1);
  assign w_row_step = w_shrink ? c_row_shr   : c_row_full;

  // Per-channel unsigned arithmetic; the extra MSB of sum/diff is carry/borrow
  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [CW-1:0] w_c;
    logic [CW:0]   w_sum;
    logic [CW:0]   w_diff;

    assign w_c    = rd_data[g*CW +: CW];
    assign w_sum  = {1'b0, w_c} + {1'b0, r_level};
    assign w_diff = {1'b0, w_c} - {1'b0, r_level};

    assign w_result[g*CW +: CW] =
        (r_mode == c_mode_bright) ? (w_sum[CW]  ? {CW{1'b1}} : w_sum[CW-1:0])  :
        (r_mode == c_mode_dark)   ? (w_diff[CW] ? {CW{1'b0}} : w_diff[CW-1:0]) :
        (r_mode == c_mode_inv)    ? ~w_c                                        :
        (r_mode == c_mode_thr)    ? ((w_c >= r_level) ? {CW{1'b1}} : {CW{1'b0}}) :
                                    w_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    rd_en   = 1'b0;
    m_valid = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start && w_mode_ok) w_next = S_RD;
      end
      S_RD: begin
        rd_en  = 1'b1;
        w_next = S_LAT;
      end
      S_LAT: w_next = S_OUT;
      S_OUT: begin
        m_valid = 1'b1;
        if (m_ready) w_next = r_eof ? S_DONE : S_RD;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode     <= '0;
      r_level    <= '0;
      r_ox       <= '0;
      r_oy       <= '0;
      r_row_base <= '0;
      r_col_off  <= '0;
      r_m_data   <= '0;
      r_sof      <= 1'b0;
      r_eol      <= 1'b0;
      r_eof      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_mode_ok) begin
              r_mode     <= mode;
              r_level    <= level;
              r_ox       <= '0;
              r_oy       <= '0;
              r_row_base <= '0;
              r_col_off  <= '0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_LAT: begin
          r_m_data <= w_result;
          r_sof    <= (r_ox == '0) && (r_oy == '0);
          r_eol    <= (r_ox == w_ow_m1);
          r_eof    <= (r_ox == w_ow_m1) && (r_oy == w_oh_m1);
        end
        S_OUT: begin
          // Address = row base + column offset; no advance after the last beat
          if (m_ready && !r_eof) begin
            if (r_eol) begin
              r_ox       <= '0;
              r_oy       <= r_oy + YW'(1);
              r_col_off  <= '0;
              r_row_base <= r_row_base + w_row_step;
            end else begin
              r_ox      <= r_ox + XW'(1);
              r_col_off <= r_col_off + w_col_step;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_addr = r_row_base + r_col_off;
  assign m_data  = r_m_data;
  assign m_sof   = r_sof;
  assign m_eol   = r_eol;
  assign m_eof   = r_eof;
  assign err     = r_err;

endmodule

`default_nettype wire
